// File: rtl/mor1kx_bus_slave_wb32_pkg.sv
// Shared constants for the mor1kx Wishbone B3 32-bit RAM slave.
//   CTI_*   : Wishbone cycle type identifiers
//   BTE_*   : Wishbone burst type extensions
//   ST_*    : slave FSM state encoding
//   wrap_mask() : low-address bits that advance inside a wrapping burst
package mor1kx_bus_slave_wb32_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_ERR      = 2'd2;
    localparam logic [1:0] ST_BURST    = 2'd3;

    // Bits of the word address that count inside a wrapping burst; zero for linear.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  wrap_mask = 4'h3;
            BTE_WRAP8:  wrap_mask = 4'h7;
            BTE_WRAP16: wrap_mask = 4'hf;
            default:    wrap_mask = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/mor1kx_wb_burst_adr_next.sv
// Combinational next-word-address predictor for Wishbone registered-feedback bursts.
//   adr  in  AW   current word address
//   bte  in  2    burst type (linear / wrap4 / wrap8 / wrap16)
//   nxt  out AW   predicted word address of the following beat
//   ovf  out 1    linear increment carried out of the AW-bit window
module mor1kx_wb_burst_adr_next
    import mor1kx_bus_slave_wb32_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic [AW-1:0] adr,
    input  logic [1:0]    bte,
    output logic [AW-1:0] nxt,
    output logic          ovf
);

    logic [AW:0]   inc;
    logic [AW-1:0] mask;

    always_comb begin
        inc  = {1'b0, adr} + (AW+1)'(1);
        mask = AW'(wrap_mask(bte));
        if (bte == BTE_LINEAR) begin
            nxt = inc[AW-1:0];
            ovf = inc[AW];
        end else begin
            // Wrapping: upper bits held, low log2(N) bits count modulo N.
            nxt = (adr & ~mask) | (inc[AW-1:0] & mask);
            ovf = 1'b0;
        end
    end

endmodule

// File: rtl/mor1kx_bus_slave_wb32.sv
// Wishbone B3 32-bit slave bridging bus accesses onto a synchronous single-port SRAM
// with one cycle of read latency.
//   clk, rst                      clock, asynchronous active-high reset
//   wbs_adr/dat/sel/we/cyc/stb_i  Wishbone request (adr[1:0] ignored)
//   wbs_cti_i, wbs_bte_i          cycle / burst type (used only with bursts enabled)
//   wbs_dat/ack/err/rty_o         Wishbone response (rty tied 0)
//   mem_en/we/addr/wdat_o         SRAM request; mem_rdat_i valid the cycle after mem_en_o
// Define MOR1KX_WBS_BURST_EN to add the BURST state with linear/wrap address prediction;
// without it every access is classic (2 cycles, one ack).
module mor1kx_bus_slave_wb32
    import mor1kx_bus_slave_wb32_pkg::*;
#(
    parameter int unsigned MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic              wbs_we_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic [2:0]        wbs_cti_i,
    input  logic [1:0]        wbs_bte_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              wbs_rty_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [31:0]       mem_wdat_o,
    input  logic [31:0]       mem_rdat_i
);

    logic [1:0]        state_q, state_d;
    logic [MEM_AW-1:0] burst_adr_q, burst_adr_d;  // address of data now on mem_rdat_i
    logic              ovf_q, ovf_d;              // that address fell past the window
    logic [MEM_AW-1:0] nxt_adr;
    logic              nxt_ovf;
    logic              hit;
    logic [MEM_AW-1:0] adr_w;

    assign hit   = wbs_adr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2];
    assign adr_w = wbs_adr_i[MEM_AW+1:2];

    mor1kx_wb_burst_adr_next #(
        .AW (MEM_AW)
    ) u_adr_next (
        .adr (burst_adr_q),
        .bte (wbs_bte_i),
        .nxt (nxt_adr),
        .ovf (nxt_ovf)
    );

    logic unused_bits;
`ifdef MOR1KX_WBS_BURST_EN
    assign unused_bits = ^wbs_adr_i[1:0];
`else
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_cti_i, nxt_adr, nxt_ovf, ovf_q};
`endif

    always_comb begin
        state_d     = state_q;
        burst_adr_d = burst_adr_q;
        ovf_d       = ovf_q;
        wbs_ack_o   = 1'b0;
        wbs_err_o   = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 4'b0000;
        mem_addr_o  = adr_w;
        // Outputs stay at reset values while rst is held, even with a request pending.
        if (!rst && !wbs_cyc_i) begin
            state_d = ST_IDLE;
        end else if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wbs_stb_i && hit) begin
                        mem_en_o    = 1'b1;
                        mem_we_o    = wbs_we_i ? wbs_sel_i : 4'b0000;
                        burst_adr_d = adr_w;
                        ovf_d       = 1'b0;
                        state_d     = ST_ACK;
`ifdef MOR1KX_WBS_BURST_EN
                        if (wbs_cti_i == CTI_INC) state_d = ST_BURST;
`endif
                    end else if (wbs_stb_i) begin
                        state_d = ST_ERR;
                    end
                end
                ST_ACK: begin
                    wbs_ack_o = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_ERR: begin
                    wbs_err_o = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_BURST: begin
                    state_d = ST_IDLE;
`ifdef MOR1KX_WBS_BURST_EN
                    if (!wbs_stb_i) begin
                        state_d = ST_IDLE;
                    end else if (wbs_we_i) begin
                        // Writes land with the beat being acked; re-writing beat 0 is harmless.
                        if (!hit) begin
                            wbs_err_o = 1'b1;
                        end else begin
                            wbs_ack_o = 1'b1;
                            mem_en_o  = 1'b1;
                            mem_we_o  = wbs_sel_i;
                            if (wbs_cti_i == CTI_INC) state_d = ST_BURST;
                        end
                    end else if (ovf_q) begin
                        wbs_err_o = 1'b1;
                    end else if (hit && adr_w == burst_adr_q) begin
                        wbs_ack_o = 1'b1;
                        if (wbs_cti_i == CTI_INC) begin
                            // Prefetch the predicted beat so the next ack needs no wait.
                            mem_en_o    = 1'b1;
                            mem_addr_o  = nxt_adr;
                            burst_adr_d = nxt_adr;
                            ovf_d       = nxt_ovf;
                            state_d     = ST_BURST;
                        end
                    end
                    // Mispredicted read: no ack, IDLE re-issues it as a fresh request.
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign wbs_dat_o  = (wbs_ack_o && !wbs_we_i) ? mem_rdat_i : 32'h0;
    assign wbs_rty_o  = 1'b0;
    assign mem_wdat_o = wbs_dat_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            burst_adr_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_adr_q <= burst_adr_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
